// File: rtl/alu_pkg.sv
// Shared ALU types: flag bundle, default geometry and the flag derivation
// used by the pipelined add/subtract unit.
package alu_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SLICE = 8;
   localparam int DEF_TAGW  = 4;

   typedef struct packed {
      logic zero;
      logic overflow;
      logic negative;
   } flags_t;

   // Payload carried between stages for the default geometry; the top level
   // declares the same layout at its own parameterised width.
   typedef struct packed {
      logic [DEF_WIDTH-1:0] a;
      logic [DEF_WIDTH-1:0] b;
      logic [DEF_WIDTH-1:0] res;
      logic                 carry;
      logic                 all_zero;
      logic                 sub;
      logic                 sgn;
      logic [DEF_TAGW-1:0]  tag;
   } stage_pld_t;

   // Flags from the carries around the result MSB. For unsigned subtract the
   // final carry is an inverted borrow, so A<B shows up as cout=0.
   function automatic flags_t calc_flags(
      input logic sgn,
      input logic sub,
      input logic cin_msb,
      input logic cout,
      input logic s_msb,
      input logic all_zero
   );
      flags_t f;
      logic   ovf;
      if (sgn) begin
         ovf = cin_msb ^ cout;
      end else if (sub) begin
         ovf = ~cout;
      end else begin
         ovf = cout;
      end
      f.overflow = ovf;
      f.negative = sgn ? (s_msb ^ ovf) : (sub & ~cout);
      f.zero     = all_zero & ~ovf;
      return f;
   endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Handshake and data bus of the pipelined add/subtract unit.
// master: the producer/consumer side; slave: the unit itself.
interface addsub_pipe_if #(
   parameter int WIDTH = 32,
   parameter int TAGW  = 4
);
   logic             In_Valid;
   logic             In_Ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Sub;
   logic             Signed;
   logic [TAGW-1:0]  Tag_In;
   logic             Out_Valid;
   logic             Out_Ready;
   logic [WIDTH-1:0] S;
   logic             Zero;
   logic             Overflow;
   logic             Negative;
   logic [TAGW-1:0]  Tag_Out;

   modport master (
      output In_Valid, A, B, Sub, Signed, Tag_In, Out_Ready,
      input  In_Ready, Out_Valid, S, Zero, Overflow, Negative, Tag_Out
   );

   modport slave (
      input  In_Valid, A, B, Sub, Signed, Tag_In, Out_Ready,
      output In_Ready, Out_Valid, S, Zero, Overflow, Negative, Tag_Out
   );
endinterface

// File: rtl/addsub_slice.sv
// One SLICE-bit ripple chunk of the pipelined adder. Also reports the carry
// into its own MSB (needed for signed overflow) and whether its sum is zero.
module addsub_slice #(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] sum,
   output logic             cout,
   output logic             cin_msb,
   output logic             zero
);
   logic [SLICE:0] full;

   assign full    = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
   assign sum     = full[SLICE-1:0];
   assign cout    = full[SLICE];
   // a ^ b ^ carry_in = sum at any bit, so the MSB carry-in falls out directly
   assign cin_msb = a[SLICE-1] ^ b[SLICE-1] ^ sum[SLICE-1];
   assign zero    = ~|sum;
endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit: one SLICE-bit chunk per stage with the carry
// registered between stages. Operands shift right as they are consumed
// (skew), result slices shift in from the top (deskew), so after the last
// stage the result is fully aligned. A single global stall freezes all stages.
module addsub_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE,
   parameter int TAGW  = DEF_TAGW
) (
   input logic          clk,
   input logic          reset,
   addsub_pipe_if.slave bus
);
   // WIDTH must be a multiple of SLICE
   localparam int STAGES = WIDTH / SLICE;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] res;
      logic             carry;
      logic             all_zero;
      logic             sub;
      logic             sgn;
      logic [TAGW-1:0]  tag;
   } pld_t;

   pld_t              pld_in;
   pld_t              pld_d [STAGES];
   pld_t              pld_q [STAGES];
   logic [STAGES-1:0] vld_d;
   logic [STAGES-1:0] vld_q;
   flags_t            flags_d;
   flags_t            flags_q;
   logic              adv;

   assign adv = ~vld_q[STAGES-1] | bus.Out_Ready;

   // Stage-0 payload straight from the bus; subtract is A + ~B + 1
   always_comb begin
      pld_in          = '0;
      pld_in.a        = bus.A;
      pld_in.b        = bus.Sub ? ~bus.B : bus.B;
      pld_in.carry    = bus.Sub;
      pld_in.all_zero = 1'b1;
      pld_in.sub      = bus.Sub;
      pld_in.sgn      = bus.Signed;
      pld_in.tag      = bus.Tag_In;
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      pld_t             prev;
      logic [SLICE-1:0] sum;
      logic             cout;
      logic             cin_msb;
      logic             slice_zero;
      logic [WIDTH-1:0] res_nxt;

      if (i == 0) begin : g_first
         assign prev     = pld_in;
         assign vld_d[i] = bus.In_Valid;
      end else begin : g_rest
         assign prev     = pld_q[i-1];
         assign vld_d[i] = vld_q[i-1];
      end

      addsub_slice #(.SLICE(SLICE)) u_slice (
         .a       (prev.a[SLICE-1:0]),
         .b       (prev.b[SLICE-1:0]),
         .cin     (prev.carry),
         .sum     (sum),
         .cout    (cout),
         .cin_msb (cin_msb),
         .zero    (slice_zero)
      );

      if (STAGES == 1) begin : g_single
         assign res_nxt = sum;
      end else begin : g_multi
         assign res_nxt = {sum, prev.res[WIDTH-1:SLICE]};
      end

      assign pld_d[i] = '{
         a:        prev.a >> SLICE,
         b:        prev.b >> SLICE,
         res:      res_nxt,
         carry:    cout,
         all_zero: prev.all_zero & slice_zero,
         sub:      prev.sub,
         sgn:      prev.sgn,
         tag:      prev.tag
      };

      // The MSB slice lives in the last stage, so flags are formed there and
      // registered together with the completed result.
      if (i == STAGES - 1) begin : g_last
         assign flags_d = calc_flags(prev.sgn, prev.sub, cin_msb, cout,
                                     sum[SLICE-1],
                                     prev.all_zero & slice_zero);
      end
   end

   // Pipeline registers: reset flushes everything, otherwise advance on adv.
   // Bubbles still clock their (deterministic) data through.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q   <= '0;
         flags_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            pld_q[i] <= '0;
         end
      end else if (adv) begin
         vld_q   <= vld_d;
         flags_q <= flags_d;
         for (int i = 0; i < STAGES; i++) begin
            pld_q[i] <= pld_d[i];
         end
      end
   end

   assign bus.In_Ready  = adv & ~reset;
   assign bus.Out_Valid = vld_q[STAGES-1];
   assign bus.S         = pld_q[STAGES-1].res;
   assign bus.Tag_Out   = pld_q[STAGES-1].tag;
   assign bus.Zero      = flags_q.zero;
   assign bus.Overflow  = flags_q.overflow;
   assign bus.Negative  = flags_q.negative;
endmodule
